render_ctrl_spi: RTL and testbench



---
 rtl/render_ctrl_spi_pkg.sv | 17 +
 rtl/render_ctrl_spi_serial_cfg_rx.sv | 79 +++++++
 rtl/render_ctrl_spi.sv | 149 ++++++++++++++
 tb/tb_render_ctrl_spi.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_ctrl_spi_pkg.sv
// Shared types and default parameters for the render controller and its
// serial configuration receiver.
package render_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_FB = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int DEF_CFG_WIDTH   = 52;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_PIX_W       = 17;
  localparam int DEF_NUM_PIXELS  = 120000;

endpackage

// File: rtl/render_ctrl_spi_serial_cfg_rx.sv
// Serial configuration receiver: pin synchronisers, sclk/sen edge detection,
// shift register with load-for-readback, and the commit strobe.
module serial_cfg_rx
  import render_ctrl_pkg::*;
#(
  parameter int CFG_WIDTH   = DEF_CFG_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 combined_rst_n,
  input  logic                 sen_pin,
  input  logic                 sclk_pin,
  input  logic                 sdata_pin,
  input  logic [CFG_WIDTH-1:0] active_cfg,
  output logic                 readback,
  output logic                 commit,
  output logic [CFG_WIDTH-1:0] shift_word
);

  // Bit 2 = sen, bit 1 = sclk, bit 0 = sdata.
  logic [2:0]           pin_sync_reg [SYNC_STAGES];
  logic                 sen_q;
  logic                 sclk_q;
  logic                 sdata_q;
  logic                 sen_p_reg;
  logic                 sclk_p_reg;
  logic                 load;
  logic                 shift;
  logic [CFG_WIDTH-1:0] shift_reg;
  logic                 readback_reg;

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pin_sync_reg[i] <= '0;
      end
    end else begin
      pin_sync_reg[0] <= {sen_pin, sclk_pin, sdata_pin};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pin_sync_reg[i] <= pin_sync_reg[i-1];
      end
    end
  end

  assign {sen_q, sclk_q, sdata_q} = pin_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      sen_p_reg  <= 1'b0;
      sclk_p_reg <= 1'b0;
    end else begin
      sen_p_reg  <= sen_q;
      sclk_p_reg <= sclk_q;
    end
  end

  // Commit on the sen fall can never coincide with a shift, which needs sen_q high.
  assign load   = ~sen_p_reg & sen_q;
  assign shift  = sen_q & ~sclk_p_reg & sclk_q;
  assign commit = sen_p_reg & ~sen_q;

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      shift_reg    <= '0;
      readback_reg <= 1'b0;
    end else begin
      if (load) begin
        shift_reg <= active_cfg;
      end else if (shift) begin
        shift_reg <= {sdata_q, shift_reg[CFG_WIDTH-1:1]};
      end
      readback_reg <= shift_reg[0];
    end
  end

  assign readback   = readback_reg;
  assign shift_word = shift_reg;

endmodule

// File: rtl/render_ctrl_spi.sv
// Render control top: active config register, per-pixel run/write sequencing,
// mid-frame abort on commit, pixel counter and frame-consistency flag.
module render_ctrl_spi
  import render_ctrl_pkg::*;
#(
  parameter int CFG_WIDTH   = DEF_CFG_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS
) (
  input  logic                 clk,
  input  logic                 combined_rst_n,
  input  logic                 sen_in,
  input  logic                 sclk_in,
  input  logic                 sdata_in,
  output logic                 sdata_out,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 run_pixel,
  output logic                 reset_write_ptr,
  output logic                 abort,
  input  logic                 pixel_done,
  input  logic                 frame_last,
  input  logic                 wrote_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [PIX_W-1:0]     pixel_count
);

  localparam logic [PIX_W:0] FRAME_PIXELS = (PIX_W+1)'(NUM_PIXELS);

  logic                 commit;
  logic [CFG_WIDTH-1:0] shift_word;

  serial_cfg_rx #(
    .CFG_WIDTH   (CFG_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk            (clk),
    .combined_rst_n (combined_rst_n),
    .sen_pin        (sen_in),
    .sclk_pin       (sclk_in),
    .sdata_pin      (sdata_in),
    .active_cfg     (cfg_out),
    .readback       (sdata_out),
    .commit         (commit),
    .shift_word     (shift_word)
  );

  state_t               state_reg, state_next;
  logic [CFG_WIDTH-1:0] cfg_reg, cfg_next;
  logic [PIX_W-1:0]     count_reg, count_next;
  logic [PIX_W:0]       count_inc;
  logic                 hit_count;
  logic                 err_reg, err_next;
  logic                 busy_reg, busy_next;
  logic                 run_reg, run_next;
  logic                 rwp_reg, rwp_next;
  logic                 abort_reg, abort_next;
  logic                 done_reg, done_next;

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      state_reg <= IDLE;
      cfg_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      run_reg   <= 1'b0;
      rwp_reg   <= 1'b0;
      abort_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cfg_reg   <= cfg_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      run_reg   <= run_next;
      rwp_reg   <= rwp_next;
      abort_reg <= abort_next;
      done_reg  <= done_next;
    end
  end

  assign count_inc = {1'b0, count_reg} + (PIX_W+1)'(1);
  assign hit_count = (count_inc == FRAME_PIXELS);

  always_comb begin
    state_next = state_reg;
    cfg_next   = cfg_reg;
    count_next = count_reg;
    err_next   = err_reg;
    run_next   = 1'b0;
    rwp_next   = 1'b0;
    abort_next = 1'b0;
    done_next  = 1'b0;

    // A commit pre-empts whatever the engine reports in the same cycle.
    if (commit) begin
      cfg_next   = shift_word;
      state_next = START;
      abort_next = (state_reg != IDLE);
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        START: begin
          rwp_next   = 1'b1;
          run_next   = 1'b1;
          count_next = '0;
          state_next = RUN;
        end
        RUN: begin
          if (pixel_done) begin
            count_next = count_inc[PIX_W-1:0];
            if (frame_last || hit_count) begin
              state_next = IDLE;
              done_next  = 1'b1;
              if (frame_last != hit_count) begin
                err_next = 1'b1;
              end
            end else begin
              state_next = WAIT_FB;
            end
          end
        end
        WAIT_FB: begin
          if (wrote_data) begin
            run_next   = 1'b1;
            state_next = RUN;
          end
        end
        default: ;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign cfg_out         = cfg_reg;
  assign pixel_count     = count_reg;
  assign frame_err       = err_reg;
  assign busy            = busy_reg;
  assign run_pixel       = run_reg;
  assign reset_write_ptr = rwp_reg;
  assign abort           = abort_reg;
  assign frame_done      = done_reg;

endmodule

// File: tb/tb_render_ctrl_spi.sv
// Scoreboard bench for render_ctrl_spi: serial load/readback/commit, frame
// sequencing, frame_last/count mismatches, mid-frame abort and async reset.
module tb_render_ctrl_spi;

  localparam int CW   = 52;
  localparam int SS   = 3;
  localparam int PW   = 17;
  localparam int NP   = 4;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          combined_rst_n = 1'b1;
  logic          sen_in = 1'b0;
  logic          sclk_in = 1'b0;
  logic          sdata_in = 1'b0;
  logic          pixel_done = 1'b0;
  logic          frame_last = 1'b0;
  logic          wrote_data = 1'b0;
  logic          sdata_out;
  logic [CW-1:0] cfg_out;
  logic          run_pixel;
  logic          reset_write_ptr;
  logic          abort;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic [PW-1:0] pixel_count;

  int errors = 0;
  int checks = 0;
  int run_cnt = 0;
  int done_cnt = 0;

  // Reference model of the controller as seen from the pins.
  logic [CW-1:0] exp_cfg = '0;
  logic          exp_err = 1'b0;
  logic          exp_busy = 1'b0;
  int            exp_count = 0;

  logic          rb_q[$];
  logic [CW-1:0] cfg_q[$];
  int            count_q[$];

  render_ctrl_spi #(
    .CFG_WIDTH   (CW),
    .SYNC_STAGES (SS),
    .PIX_W       (PW),
    .NUM_PIXELS  (NP)
  ) dut (
    .clk             (clk),
    .combined_rst_n  (combined_rst_n),
    .sen_in          (sen_in),
    .sclk_in         (sclk_in),
    .sdata_in        (sdata_in),
    .sdata_out       (sdata_out),
    .cfg_out         (cfg_out),
    .run_pixel       (run_pixel),
    .reset_write_ptr (reset_write_ptr),
    .abort           (abort),
    .pixel_done      (pixel_done),
    .frame_last      (frame_last),
    .wrote_data      (wrote_data),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .pixel_count     (pixel_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (run_pixel) run_cnt <= run_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // Full serial transfer followed by commit; optionally fires pixel_done
  // in exactly the cycle the commit is seen internally.
  task automatic spi_xfer(input logic [CW-1:0] w, input bit coincide, input string tag);
    logic [CW-1:0] old_cfg;
    logic [CW-1:0] exp_word;
    logic          exp_bit;
    old_cfg = exp_cfg;
    for (int i = 0; i < CW; i++) rb_q.push_back(exp_cfg[i]);
    sen_in = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < CW; i++) begin
      sdata_in = w[i];
      repeat (HALF) @(negedge clk);
      exp_bit = rb_q.pop_front();
      checks++;
      if (sdata_out !== exp_bit) begin
        errors++;
        $display("FAIL readback[%0d] %s: got %b want %b", i, tag, sdata_out, exp_bit);
      end
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    sen_in = 1'b0;
    cfg_q.push_back(w);
    repeat (SS) @(negedge clk);
    checks++;
    if (cfg_out !== old_cfg) begin
      errors++;
      $display("FAIL cfg_hold %s: got %h want %h", tag, cfg_out, old_cfg);
    end
    if (coincide) begin
      pixel_done = 1'b1;
      frame_last = 1'b1;
    end
    @(negedge clk);
    pixel_done = 1'b0;
    frame_last = 1'b0;
    exp_word = cfg_q.pop_front();
    checks++;
    if (cfg_out !== exp_word) begin
      errors++;
      $display("FAIL cfg_commit %s: got %h want %h", tag, cfg_out, exp_word);
    end
    checks++;
    if ({busy, abort, frame_err, frame_done, run_pixel} !== {1'b1, exp_busy, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL commit_flags %s: got busy/abort/err/done/run=%b%b%b%b%b want 1%b000",
               tag, busy, abort, frame_err, frame_done, run_pixel, exp_busy);
    end
    if (coincide) begin
      checks++;
      if (pixel_count !== PW'(exp_count)) begin
        errors++;
        $display("FAIL discard_pixel %s: got %0d want %0d", tag, pixel_count, exp_count);
      end
    end
    @(negedge clk);
    checks++;
    if ({run_pixel, reset_write_ptr, abort} !== 3'b110) begin
      errors++;
      $display("FAIL start_pulse %s: got run/rwp/abort=%b%b%b want 110",
               tag, run_pixel, reset_write_ptr, abort);
    end
    checks++;
    if (pixel_count !== '0) begin
      errors++;
      $display("FAIL start_count %s: got %0d want 0", tag, pixel_count);
    end
    exp_cfg   = w;
    exp_err   = 1'b0;
    exp_busy  = 1'b1;
    exp_count = 0;
    $display("spi %s: wrote %h, read back %h", tag, w, old_cfg);
  endtask

  // One pixel: pixel_done (with frame_last when chosen), then wrote_data
  // unless the frame ended.  Assumes run_pixel for this pixel has been seen.
  task automatic step_pixel(input int last_at, input bit give_write, input string tag,
                            output bit fin);
    bit            fl;
    bit            hit;
    logic [PW-1:0] want;
    repeat (2) @(negedge clk);
    fl = (exp_count + 1 == last_at);
    pixel_done = 1'b1;
    frame_last = fl;
    exp_count++;
    hit = (exp_count == NP);
    fin = fl || hit;
    if (fl != hit) exp_err = 1'b1;
    count_q.push_back(exp_count);
    @(negedge clk);
    pixel_done = 1'b0;
    frame_last = 1'b0;
    want = PW'(count_q.pop_front());
    checks++;
    if (pixel_count !== want) begin
      errors++;
      $display("FAIL pixel_count %s: got %0d want %0d", tag, pixel_count, want);
    end
    checks++;
    if ({frame_done, busy} !== {fin, ~fin}) begin
      errors++;
      $display("FAIL done_busy %s: got done/busy=%b%b want %b%b", tag, frame_done, busy, fin, ~fin);
    end
    if (fin) begin
      exp_busy = 1'b0;
      checks++;
      if (frame_err !== exp_err) begin
        errors++;
        $display("FAIL frame_err %s: got %b want %b", tag, frame_err, exp_err);
      end
    end else if (give_write) begin
      repeat (2) @(negedge clk);
      wrote_data = 1'b1;
      @(negedge clk);
      wrote_data = 1'b0;
      checks++;
      if (run_pixel !== 1'b1) begin
        errors++;
        $display("FAIL run_after_write %s: got %b want 1", tag, run_pixel);
      end
    end
  endtask

  task automatic do_frame(input int last_at, input string tag);
    bit fin;
    fin = 1'b0;
    for (int guard = 0; guard < NP + 2 && !fin; guard++) begin
      step_pixel(last_at, 1'b1, tag, fin);
    end
    if (!fin) begin
      errors++;
      $display("FAIL frame_end %s: frame never ended, got count %0d want end", tag, pixel_count);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle %s: got %b want 0", tag, frame_done);
    end
    $display("frame %s: pixels=%0d err=%b", tag, pixel_count, frame_err);
  endtask

  task automatic test_reset();
    #2 combined_rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_out, pixel_count} !== '0 ||
        {run_pixel, reset_write_ptr, abort, busy, frame_done, frame_err, sdata_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got cfg=%h cnt=%0d busy=%b sdo=%b want all 0",
               cfg_out, pixel_count, busy, sdata_out);
    end
    repeat (3) @(negedge clk);
    combined_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, run_pixel, cfg_out} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b run=%b cfg=%h want 0", busy, run_pixel, cfg_out);
    end
    $display("reset: done");
  endtask

  task automatic test_load_and_frame();
    int run_base;
    int done_base;
    run_base  = run_cnt;
    done_base = done_cnt;
    spi_xfer(52'hA5A5A12345678, 1'b0, "load");
    do_frame(NP, "full");
    checks++;
    if (run_cnt - run_base != NP) begin
      errors++;
      $display("FAIL run_pulses: got %0d want %0d", run_cnt - run_base, NP);
    end
    checks++;
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt - done_base);
    end
  endtask

  task automatic test_readback_early_last();
    spi_xfer('0, 1'b0, "readback");
    do_frame(2, "early_last");
  endtask

  task automatic test_count_limit();
    spi_xfer(52'h3C3C_0F0F_9999_1, 1'b0, "clear_err");
    do_frame(0, "no_last");
  endtask

  task automatic test_abort();
    bit fin;
    int done_base;
    spi_xfer(52'h1_2345_6789_ABCD, 1'b0, "pre_abort");
    step_pixel(0, 1'b1, "abort_p1", fin);
    done_base = done_cnt;
    spi_xfer(52'hF_EDCB_A987_6543, 1'b1, "abort_run");
    step_pixel(0, 1'b0, "abort_p1b", fin);
    spi_xfer(52'h0_0000_FFFF_0001, 1'b0, "abort_waitfb");
    checks++;
    if (done_cnt != done_base) begin
      errors++;
      $display("FAIL no_done_on_abort: got %0d pulses want 0", done_cnt - done_base);
    end
    do_frame(NP, "after_abort");
  endtask

  task automatic test_reset_midframe();
    bit fin;
    spi_xfer(52'h5_5555_AAAA_5555, 1'b0, "pre_reset");
    step_pixel(0, 1'b1, "reset_p1", fin);
    combined_rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_out, pixel_count} !== '0 ||
        {run_pixel, reset_write_ptr, abort, busy, frame_done, frame_err, sdata_out} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got cfg=%h cnt=%0d busy=%b want all 0", cfg_out, pixel_count, busy);
    end
    exp_cfg   = '0;
    exp_busy  = 1'b0;
    exp_count = 0;
    exp_err   = 1'b0;
    repeat (2) @(negedge clk);
    combined_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pixel_done = 1'b1;
    frame_last = 1'b1;
    wrote_data = 1'b1;
    @(negedge clk);
    pixel_done = 1'b0;
    frame_last = 1'b0;
    wrote_data = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, run_pixel, frame_done, pixel_count} !== '0) begin
      errors++;
      $display("FAIL idle_ignore: got busy=%b run=%b done=%b cnt=%0d want 0",
               busy, run_pixel, frame_done, pixel_count);
    end
    $display("reset mid-frame: done");
    spi_xfer(52'h8_0000_0000_0001, 1'b0, "post_reset");
    do_frame(NP, "post_reset");
  endtask

  initial begin
    test_reset();
    test_load_and_frame();
    test_readback_early_last();
    test_count_limit();
    test_abort();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
